piso_frame_sr: RTL and testbench



---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_bit_counter.sv | 32 +++
 rtl/piso_frame_sr.sv | 92 +++++++++
 tb/tb_piso_frame_sr.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_frame_sr parallel-to-serial transmit shifter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of the bit-position counter for an n-bit frame.
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial frame; flags the strobe that completes the last bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int NUM_BITS = 10,
    localparam int CW      = cnt_w(NUM_BITS)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          count_enable,
    input  logic [CW-1:0] rollover_val,
    output logic [CW-1:0] count,
    output logic          rollover
);

    assign rollover = count_enable && (count == rollover_val);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (rollover) begin
            count <= '0;
        end else if (count_enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_frame_sr.sv
// Parallel-to-serial frame shifter: valid/ready word load, one bit per shift_enable strobe,
// gapless back-to-back frames, frame_done pulse and synchronous abort.
module piso_frame_sr
    import piso_pkg::*;
#(
    parameter int NUM_BITS  = 10,
    parameter bit SHIFT_MSB = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic                clear,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    localparam int                  CW        = cnt_w(NUM_BITS);
    localparam logic [NUM_BITS-1:0] IDLE_WORD = {NUM_BITS{IDLE_BIT}};
    localparam logic [CW-1:0]       LAST_IDX  = CW'(NUM_BITS - 1);

    state_t              state;
    logic [NUM_BITS-1:0] shreg;
    logic [NUM_BITS-1:0] shreg_shifted;
    logic [CW-1:0]       count;
    logic                bit_advance;
    logic                frame_end;
    logic                load_accept;

    assign busy        = (state == SHIFT);
    assign bit_advance = busy && shift_enable;

    // The last strobe of a frame opens the ready window so the next word lands with no gap bit.
    assign load_ready  = (state == IDLE) ||
                         (busy && (count == LAST_IDX) && shift_enable && !clear);
    assign load_accept = load_valid && load_ready && !clear;

    // The line bit comes straight off a register end, so no input reaches it combinationally.
    assign serial_out = SHIFT_MSB ? shreg[NUM_BITS-1] : shreg[0];

    piso_bit_counter #(
        .NUM_BITS(NUM_BITS)
    ) u_bit_counter (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear || load_accept),
        .count_enable(bit_advance),
        .rollover_val(LAST_IDX),
        .count       (count),
        .rollover    (frame_end)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        shreg_shifted = shreg;
        if (SHIFT_MSB) begin
            shreg_shifted = {shreg[NUM_BITS-2:0], IDLE_BIT};
        end else begin
            shreg_shifted = {IDLE_BIT, shreg[NUM_BITS-1:1]};
        end
    end

    // NOTE: the shift register drives the line directly, so it is reset like any control flop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            shreg      <= IDLE_WORD;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end && !clear;
            if (clear) begin
                state <= IDLE;
                shreg <= IDLE_WORD;
            end else if (load_accept) begin
                state <= SHIFT;
                shreg <= parallel_in;
            end else if (bit_advance) begin
                if (frame_end) begin
                    state <= IDLE;
                    shreg <= IDLE_WORD;
                end else begin
                    shreg <= shreg_shifted;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_frame_sr.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus; a scoreboard
// queue per instance holds the expected line bits for every accepted word.
module tb_piso_frame_sr;

    localparam int NB = 10;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          shift_enable = 1'b0;
    logic          load_valid = 1'b0;
    logic          clear = 1'b0;
    logic [NB-1:0] parallel_in = '0;

    logic ready_m, so_m, busy_m, done_m;
    logic ready_l, so_l, busy_l, done_l;

    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_q_m[$];
    logic exp_q_l[$];

    typedef struct {
        logic [NB-1:0] word;
        logic [NB-1:0] seq_m;   // expected line order, first bit in [NB-1]
        logic [NB-1:0] seq_l;
        int            gap;     // idle cycles between strobes
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    piso_frame_sr #(.NUM_BITS(NB), .SHIFT_MSB(1'b1), .IDLE_BIT(1'b1)) dut_m (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .load_valid(load_valid),
        .load_ready(ready_m), .parallel_in(parallel_in), .clear(clear),
        .serial_out(so_m), .busy(busy_m), .frame_done(done_m)
    );

    piso_frame_sr #(.NUM_BITS(NB), .SHIFT_MSB(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .load_valid(load_valid),
        .load_ready(ready_l), .parallel_in(parallel_in), .clear(clear),
        .serial_out(so_l), .busy(busy_l), .frame_done(done_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        shift_enable = 1'b1;
        step();
        shift_enable = 1'b0;
    endtask

    task automatic flush();
        exp_q_m.delete();
        exp_q_l.delete();
    endtask

    task automatic push_frame(input logic [NB-1:0] sm, input logic [NB-1:0] sl);
        for (int i = NB - 1; i >= 0; i--) begin
            exp_q_m.push_back(sm[i]);
            exp_q_l.push_back(sl[i]);
        end
    endtask

    task automatic check_state(input string name, input logic so, input logic bsy, input logic dn);
        check({name, "_so_m"}, 32'(so_m), 32'(so));
        check({name, "_so_l"}, 32'(so_l), 32'(so));
        check({name, "_busy_m"}, 32'(busy_m), 32'(bsy));
        check({name, "_busy_l"}, 32'(busy_l), 32'(bsy));
        check({name, "_done_m"}, 32'(done_m), 32'(dn));
        check({name, "_done_l"}, 32'(done_l), 32'(dn));
    endtask

    // Pop the next expected bit and confirm it stays on the line through gap cycles.
    task automatic check_bit(input string name, input int gap);
        logic em, el;
        if (exp_q_m.size() == 0 || exp_q_l.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: line shows %b/%b with nothing expected", name, so_m, so_l);
        end else begin
            em = exp_q_m.pop_front();
            el = exp_q_l.pop_front();
            check({name, "_msb"}, 32'(so_m), 32'(em));
            check({name, "_lsb"}, 32'(so_l), 32'(el));
            for (int g = 0; g < gap; g++) begin
                step();
                check({name, "_hold_msb"}, 32'(so_m), 32'(em));
                check({name, "_hold_lsb"}, 32'(so_l), 32'(el));
            end
        end
    endtask

    task automatic run_bits(input string name, input int n, input int gap);
        for (int b = 0; b < n; b++) begin
            check_bit(name, gap);
            strobe();
        end
    endtask

    task automatic load_word(input string name, input logic [NB-1:0] word,
                             input logic [NB-1:0] sm, input logic [NB-1:0] sl);
        parallel_in = word;
        load_valid  = 1'b1;
        #1;
        check({name, "_ready_m"}, 32'(ready_m), 32'd1);
        check({name, "_ready_l"}, 32'(ready_l), 32'd1);
        step();
        load_valid = 1'b0;
        push_frame(sm, sl);
        check({name, "_busy_m"}, 32'(busy_m), 32'd1);
        check({name, "_busy_l"}, 32'(busy_l), 32'd1);
    endtask

    task automatic finish_frame(input string name);
        check_state({name, "_end"}, 1'b1, 1'b0, 1'b1);
        step();
        check_state({name, "_after"}, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input string name, input logic [NB-1:0] word,
                             input logic [NB-1:0] sm, input logic [NB-1:0] sl, input int gap);
        load_word(name, word, sm, sl);
        run_bits(name, NB, gap);
        finish_frame(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{word: 10'b1111001111, seq_m: 10'b1111001111, seq_l: 10'b1111001111, gap: 0};
        vecs[1] = '{word: 10'b0000000001, seq_m: 10'b0000000001, seq_l: 10'b1000000000, gap: 0};
        vecs[2] = '{word: 10'b0001111100, seq_m: 10'b0001111100, seq_l: 10'b0011111000, gap: 2};
        vecs[3] = '{word: 10'b1010000011, seq_m: 10'b1010000011, seq_l: 10'b1100000101, gap: 1};

        // Reset
        step();
        step();
        check_state("in_reset", 1'b1, 1'b0, 1'b0);
        n_rst = 1'b1;
        step();
        check_state("post_reset", 1'b1, 1'b0, 1'b0);
        check("post_reset_ready_m", 32'(ready_m), 32'd1);
        check("post_reset_ready_l", 32'(ready_l), 32'd1);

        // Strobes in IDLE do nothing
        shift_enable = 1'b1;
        step();
        step();
        shift_enable = 1'b0;
        check_state("idle_strobe", 1'b1, 1'b0, 1'b0);

        // Table-driven frames, including gapped strobes
        foreach (vecs[i]) begin
            run_frame($sformatf("vec%0d", i), vecs[i].word, vecs[i].seq_m, vecs[i].seq_l, vecs[i].gap);
        end

        // Back-to-back: second word held from the start of the first frame
        load_word("b2b_a", vecs[0].word, vecs[0].seq_m, vecs[0].seq_l);
        parallel_in = vecs[2].word;
        load_valid  = 1'b1;
        for (int b = 0; b < NB; b++) begin
            check_bit("b2b_a", 0);
            shift_enable = 1'b1;
            #1;
            if (b < NB - 1) begin
                check("b2b_ready_low_m", 32'(ready_m), 32'd0);
                check("b2b_ready_low_l", 32'(ready_l), 32'd0);
            end else begin
                check("b2b_ready_high_m", 32'(ready_m), 32'd1);
                check("b2b_ready_high_l", 32'(ready_l), 32'd1);
                push_frame(vecs[2].seq_m, vecs[2].seq_l);
            end
            step();
            shift_enable = 1'b0;
        end
        load_valid = 1'b0;
        check("b2b_done_m", 32'(done_m), 32'd1);
        check("b2b_done_l", 32'(done_l), 32'd1);
        check("b2b_busy_m", 32'(busy_m), 32'd1);
        check("b2b_busy_l", 32'(busy_l), 32'd1);
        run_bits("b2b_b", NB, 0);
        finish_frame("b2b_b");

        // Abort after strobe 4, with a competing load held
        load_word("abort", vecs[3].word, vecs[3].seq_m, vecs[3].seq_l);
        run_bits("abort", 4, 0);
        clear        = 1'b1;
        shift_enable = 1'b1;
        load_valid   = 1'b1;
        parallel_in  = vecs[1].word;
        step();
        clear        = 1'b0;
        shift_enable = 1'b0;
        load_valid   = 1'b0;
        check_state("abort", 1'b1, 1'b0, 1'b0);
        step();
        check_state("abort_next", 1'b1, 1'b0, 1'b0);
        flush();

        // Clear in IDLE blocks a load even though ready reads 1
        clear      = 1'b1;
        load_valid = 1'b1;
        #1;
        check("idle_clear_ready_m", 32'(ready_m), 32'd1);
        step();
        clear      = 1'b0;
        load_valid = 1'b0;
        check_state("idle_clear", 1'b1, 1'b0, 1'b0);

        // Fresh load after abort restarts at the first bit
        run_frame("restart", vecs[1].word, vecs[1].seq_m, vecs[1].seq_l, 0);

        // Clear on the final strobe suppresses frame_done
        load_word("late_clear", vecs[2].word, vecs[2].seq_m, vecs[2].seq_l);
        run_bits("late_clear", NB - 1, 0);
        check_bit("late_clear_last", 0);
        clear        = 1'b1;
        shift_enable = 1'b1;
        load_valid   = 1'b1;
        #1;
        check("late_clear_ready_m", 32'(ready_m), 32'd0);
        step();
        clear        = 1'b0;
        shift_enable = 1'b0;
        load_valid   = 1'b0;
        check_state("late_clear", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, observed before the next clock edge
        load_word("arst", vecs[3].word, vecs[3].seq_m, vecs[3].seq_l);
        run_bits("arst", 3, 0);
        check_bit("arst_pre", 0);
        #2;
        n_rst = 1'b0;
        #1;
        check_state("arst", 1'b1, 1'b0, 1'b0);
        check("arst_ready_m", 32'(ready_m), 32'd1);
        step();
        n_rst = 1'b1;
        flush();
        step();
        run_frame("resume", vecs[3].word, vecs[3].seq_m, vecs[3].seq_l, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
